// File: rtl/output_stream_packer_pkg.sv
// Shared sizing for the output stream packer: lane geometry, beats per vector,
// the buffered vector entry and the serialiser states.
package output_stream_packer_pkg;

  localparam int N_DIM_ARRAY    = 8;
  localparam int ACT_DATA_WIDTH = 8;
  localparam int VEC_BITS       = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int BEATS          = VEC_BITS / 32;
  localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [31:0]                                addr;
    logic [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0] data;
  } vec_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } pack_state_e;

endpackage

// File: rtl/output_stream_packer_if.sv
// 32-bit beat stream with valid/ready handshake; master drives the beats.
interface output_stream_packer_if;

  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_last;
  logic        out_ready;

  modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);

endinterface

// File: rtl/output_stream_packer_fifo.sv
// output_vector_fifo: synchronous vector FIFO with a registered head entry,
// so the serialiser sees the oldest vector straight from a flop.
module output_vector_fifo
  import output_stream_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  vec_entry_t             wr_data,
  input  logic                   rd_en,
  output vec_entry_t             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("output_vector_fifo: DEPTH must be a power of two >= 2");
  end

  vec_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign level      = count;
  assign do_rd      = rd_en && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign do_wr      = wr_en && (!full || do_rd);
  assign rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      // bypass when the incoming entry becomes the new head
      rd_data <= (do_wr && wr_ptr == rd_ptr_nxt) ? wr_data : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/output_stream_packer.sv
// Buffers N-lane output vectors and streams them as 32-bit addressed beats.
// Define OUTPUT_STREAM_PACKER_DROP_CNT_EN to add a saturating drop_count port.
module output_stream_packer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int N_DIM_ARRAY    = output_stream_packer_pkg::N_DIM_ARRAY,
  parameter int ACT_DATA_WIDTH = output_stream_packer_pkg::ACT_DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       clear,
  input  logic [31:0]                                base_addr,
  input  logic                                       wr_output_enable,
  input  logic [31:0]                                wr_output_addr,
  input  logic signed [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0] wr_output_data,
  input  logic                                       finished_network,
  output_stream_packer_if.master                     stream,
  output logic [$clog2(FIFO_DEPTH):0]                fill_level,
  output logic                                       overflow,
  output logic                                       drained
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
  ,
  output logic [15:0]                                drop_count
`endif
);

  import output_stream_packer_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  if ((N_DIM_ARRAY * ACT_DATA_WIDTH) % 32 != 0 || N_DIM_ARRAY * ACT_DATA_WIDTH == 0) begin : g_bad_width
    $error("output_stream_packer: N_DIM_ARRAY*ACT_DATA_WIDTH must be a non-zero multiple of 32");
  end
  if (N_DIM_ARRAY != output_stream_packer_pkg::N_DIM_ARRAY ||
      ACT_DATA_WIDTH != output_stream_packer_pkg::ACT_DATA_WIDTH) begin : g_bad_geom
    $error("output_stream_packer: lane geometry must match the package entry type");
  end

  pack_state_e         state, state_nxt;
  vec_entry_t          head, push_entry;
  logic                fifo_full, fifo_empty;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [31:0]         base_q, beat_idx;
  logic [VEC_BITS-1:0] head_bits;
  logic                hs, last_beat, pop, push, drop, fin_q;

  assign push_entry = {wr_output_addr, wr_output_data};

  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign hs        = stream.out_valid && stream.out_ready;
  assign pop       = hs && last_beat;
  assign push      = wr_output_enable && !clear && (!fifo_full || pop);
  assign drop      = wr_output_enable && !clear && fifo_full && !pop;

  output_vector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop && !clear),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A push into an empty FIFO moves straight to STREAM so the head
  // register and state line up for a one-cycle capture-to-valid latency.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (!fifo_empty || push) state_nxt = ST_STREAM;
        ST_STREAM: if (pop && fill_level == LVL_W'(1) && !push) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Serialiser: beat data and address come from the registered head, so they
  // only move on a handshake; outputs are forced to zero outside STREAM.
  assign head_bits        = head.data;
  assign beat_idx         = head.addr * 32'(BEATS) + 32'(beat_cnt);
  assign stream.out_valid = (state == ST_STREAM);
  assign stream.out_data  = stream.out_valid ? head_bits[int'(beat_cnt)*32 +: 32] : '0;
  assign stream.out_addr  = stream.out_valid ? base_q + (beat_idx << 2) : '0;
  assign stream.out_last  = stream.out_valid && last_beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      base_q   <= '0;
      overflow <= 1'b0;
      fin_q    <= 1'b0;
      drained  <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      base_q   <= '0;
      overflow <= 1'b0;
      fin_q    <= 1'b0;
      drained  <= 1'b0;
    end else begin
      if (hs) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
      // base address is captured once at the start of every beat
      if (state_nxt == ST_STREAM && (state == ST_IDLE || hs)) base_q <= base_addr;
      if (drop) overflow <= 1'b1;
      if (finished_network) fin_q <= 1'b1;
      if (wr_output_enable)                               drained <= 1'b0;
      else if (fin_q && fifo_empty && state == ST_IDLE)   drained <= 1'b1;
    end
  end

`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 drop_count <= '0;
    else if (clear)                             drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)    drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_output_stream_packer.sv
// Bench for output_stream_packer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference of the beat stream.
module tb_output_stream_packer;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int NB    = N * W / 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear = 1'b0;
  logic                   we = 1'b0;
  logic                   fin = 1'b0;
  logic [31:0]            base_addr = '0;
  logic [31:0]            waddr = '0;
  logic [N-1:0][W-1:0]    wdata = '0;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   overflow, drained;
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
  logic [15:0]            drop_count;
`endif

  output_stream_packer_if sif();

  always #5 clk = ~clk;

  output_stream_packer #(.FIFO_DEPTH(DEPTH), .N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .clear            (clear),
    .base_addr        (base_addr),
    .wr_output_enable (we),
    .wr_output_addr   (waddr),
    .wr_output_data   (wdata),
    .finished_network (fin),
    .stream           (sif),
    .fill_level       (fill_level),
    .overflow         (overflow),
    .drained          (drained)
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  typedef struct {
    logic [31:0]         addr;
    logic [N-1:0][W-1:0] lanes;
  } vec_t;

  vec_t q[$];
  int   beat, m_ovf, m_drops;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] ramp(input logic [7:0] s);
    logic [N-1:0][W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = W'(s + 8'(i));
    return r;
  endfunction

  // beat b holds lanes b*(32/W) upward, lowest lane in the least significant bits
  function automatic logic [31:0] exp_beat(input vec_t v, input int b);
    logic [31:0] w;
    int lpb;
    w   = '0;
    lpb = 32 / W;
    for (int l = 0; l < lpb; l++) w = w | (32'(v.lanes[b*lpb + l]) << (l*W));
    return w;
  endfunction

  function automatic logic [31:0] exp_addr(input vec_t v, input int b);
    logic [31:0] idx;
    idx = v.addr * 32'(NB) + 32'(b);
    return base_addr + (idx << 2);
  endfunction

  task automatic check_outputs();
    chk("out_valid", sif.out_valid, q.size() > 0);
    chk("fill_level", fill_level, q.size());
    chk("overflow", overflow, m_ovf != 0);
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
    chk("drop_count", drop_count, m_drops);
`endif
    if (q.size() > 0) begin
      chk("out_data", sif.out_data, exp_beat(q[0], beat));
      chk("out_addr", sif.out_addr, exp_addr(q[0], beat));
      chk("out_last", sif.out_last, beat == NB - 1);
    end
  endtask

  // One cycle: check what the DUT shows, drive inputs for the next rising edge,
  // then advance the reference by that edge.
  task automatic step(input logic i_we, input logic [31:0] i_addr, input logic [N*W-1:0] i_data,
                      input logic i_rdy, input logic i_fin, input logic i_clr);
    bit   hs, pop_now;
    vec_t v;
    @(negedge clk);
    check_outputs();
    we = i_we; waddr = i_addr; wdata = i_data; sif.out_ready = i_rdy; fin = i_fin; clear = i_clr;
    if (i_clr) begin
      q.delete(); beat = 0; m_ovf = 0; m_drops = 0;
    end else begin
      hs      = (q.size() > 0) && i_rdy;
      pop_now = hs && (beat == NB - 1);
      if (hs) beat = pop_now ? 0 : beat + 1;
      if (pop_now) void'(q.pop_front());
      if (i_we) begin
        if (q.size() < DEPTH) begin
          v.addr = i_addr; v.lanes = i_data; q.push_back(v);
        end else begin
          m_ovf = 1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; beat = 0; m_ovf = 0; m_drops = 0;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drained", drained, 0);
    chk("rst_data", sif.out_data, 0);
    rst_n = 1'b1;

    // single vector
    base_addr = 32'h1000;
    step(1'b1, 32'd3, ramp(8'h01), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("t1_b0_data", sif.out_data, 32'h04030201);
    chk("t1_b0_addr", sif.out_addr, 32'h1018);
    chk("t1_b0_last", sif.out_last, 0);
    idle(1'b1);
    chk("t1_b1_data", sif.out_data, 32'h08070605);
    chk("t1_b1_addr", sif.out_addr, 32'h101C);
    chk("t1_b1_last", sif.out_last, 1);
    idle(1'b1);

    // back-pressure
    step(1'b1, 32'd5, ramp(8'h11), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("bp_data", sif.out_data, 32'h14131211);
      chk("bp_addr", sif.out_addr, 32'h1028);
      chk("bp_fill", fill_level, 1);
    end
    idle(1'b1);
    idle(1'b1);
    chk("bp_b1_data", sif.out_data, 32'h18171615);
    chk("bp_b1_addr", sif.out_addr, 32'h102C);
    idle(1'b0);

    // overflow: five pushes against a stalled consumer
    for (int i = 0; i < 5; i++) step(1'b1, 32'(16 + i), ramp(8'(8'h20 + 8*i)), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("ovf_fill", fill_level, 4);
    chk("ovf_flag", overflow, 1);
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
    chk("ovf_drops", drop_count, 1);
`endif

    // full FIFO with a push landing on the last-beat handshake
    idle(1'b1);
    step(1'b1, 32'd40, ramp(8'h80), 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("fullpop_fill", fill_level, 4);
`ifdef OUTPUT_STREAM_PACKER_DROP_CNT_EN
    chk("fullpop_drops", drop_count, 1);
`endif

    // asynchronous reset in the middle of a vector
    idle(1'b1);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", sif.out_valid, 0);
    chk("arst_data", sif.out_data, 0);
    chk("arst_addr", sif.out_addr, 0);
    chk("arst_last", sif.out_last, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drained", drained, 0);
    rst_n = 1'b1;
    q.delete(); beat = 0; m_ovf = 0; m_drops = 0;
    step(1'b1, 32'd9, ramp(8'h50), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("arst_b0_data", sif.out_data, 32'h53525150);
    chk("arst_b0_addr", sif.out_addr, 32'h1048);
    idle(1'b1);
    idle(1'b0);

    // drain after finished_network, then clear mid-stream
    base_addr = 32'h2000;
    step(1'b1, 32'd1, ramp(8'h60), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd2, ramp(8'h70), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("drain_early", drained, 0);
    end
    idle(1'b0);
    idle(1'b0);
    chk("drain_set", drained, 1);
    step(1'b1, 32'd4, ramp(8'h90), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd5, ramp(8'hA0), 1'b0, 1'b0, 1'b0);
    chk("drain_clr_by_wr", drained, 0);
    idle(1'b1);
    step(1'b1, 32'd6, ramp(8'hB0), 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    chk("clr_valid", sif.out_valid, 0);
    chk("clr_fill", fill_level, 0);

    // random traffic: congested phase then a mostly-ready phase
    base_addr = $urandom;
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 5, $urandom, {$urandom, $urandom},
           $urandom_range(0, 9) < 2, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 3, $urandom, {$urandom, $urandom},
           $urandom_range(0, 9) < 8, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    repeat (12) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
